// File: rtl/uart_cmd_sequencer.sv
// UART master command sequencer: turns 'W'/'R' frames from the RX FIFO into single bus cycles
// and pushes ACK/NAK/read data to the TX FIFO. Define UARTMASTER_TIMEOUT_EN for a bus ack timeout.
module uart_cmd_sequencer #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [7:0]    i_rx_dat,
  input  logic          i_rx_empty,
  output logic          o_rx_pop,
  output logic [7:0]    o_tx_dat,
  output logic          o_tx_push,
  input  logic          i_tx_full,
  output logic          o_bus_cyc,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_dat,
  input  logic [DW-1:0] i_bus_dat,
  input  logic          i_bus_ack,
  output logic          o_busy
);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RespAck  = 8'h06;
  localparam logic [7:0] RespNak  = 8'h15;

  // Frames carry exactly two address and two data bytes.
  if (AW == 0 || AW > 16 || DW != 16 || TIMEOUT == 0) begin : g_bad_params
    $error("uart_cmd_sequencer: unsupported AW/DW/TIMEOUT");
  end

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StBus, StResp} state_e;

  state_e          state_q;
  logic            rx_take_q;
  logic            byte_sel_q;
  logic            is_write_q;
  logic            resp_last_q;
  logic [15:0]     addr_q;
  logic [DW-1:0]   wdat_q;
  logic [7:0]      rd_lo_q;
  logic [7:0]      tx_dat_q;
  logic            bus_cyc_q;
  logic            bus_we_q;
  logic            tmo_hit;

`ifdef UARTMASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q;

  // Counter sits at zero outside BUS, so it starts cleared on every entry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_q <= '0;
    end else if (state_q != StBus) begin
      tmo_q <= '0;
    end else if (!i_bus_ack) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      rx_take_q   <= 1'b0;
      byte_sel_q  <= 1'b0;
      is_write_q  <= 1'b0;
      resp_last_q <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      rd_lo_q     <= '0;
      tx_dat_q    <= '0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
    end else begin
      // rx_take_q is the RX_TAKE half of the fetch handshake and doubles as the pop strobe.
      rx_take_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!i_rx_empty) begin
            rx_take_q <= 1'b1;
            state_q   <= StCmd;
          end
        end
        StCmd: begin
          if (rx_take_q) begin
            byte_sel_q <= 1'b0;
            if (i_rx_dat == CmdWrite || i_rx_dat == CmdRead) begin
              is_write_q <= (i_rx_dat == CmdWrite);
              state_q    <= StAddr;
            end else begin
              tx_dat_q    <= RespNak;
              resp_last_q <= 1'b1;
              state_q     <= StResp;
            end
          end
        end
        StAddr: begin
          if (rx_take_q) begin
            addr_q     <= {addr_q[7:0], i_rx_dat};
            byte_sel_q <= ~byte_sel_q;
            if (byte_sel_q) begin
              if (is_write_q) begin
                state_q <= StWdata;
              end else begin
                bus_cyc_q <= 1'b1;
                bus_we_q  <= 1'b0;
                state_q   <= StBus;
              end
            end
          end else if (!i_rx_empty) begin
            rx_take_q <= 1'b1;
          end
        end
        StWdata: begin
          if (rx_take_q) begin
            wdat_q     <= {wdat_q[DW-9:0], i_rx_dat};
            byte_sel_q <= ~byte_sel_q;
            if (byte_sel_q) begin
              bus_cyc_q <= 1'b1;
              bus_we_q  <= 1'b1;
              state_q   <= StBus;
            end
          end else if (!i_rx_empty) begin
            rx_take_q <= 1'b1;
          end
        end
        StBus: begin
          if (i_bus_ack) begin
            bus_cyc_q <= 1'b0;
            state_q   <= StResp;
            if (bus_we_q) begin
              tx_dat_q    <= RespAck;
              resp_last_q <= 1'b1;
            end else begin
              tx_dat_q    <= i_bus_dat[15:8];
              rd_lo_q     <= i_bus_dat[7:0];
              resp_last_q <= 1'b0;
            end
          end else if (tmo_hit) begin
            bus_cyc_q   <= 1'b0;
            tx_dat_q    <= RespNak;
            resp_last_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (!i_tx_full) begin
            if (resp_last_q) begin
              state_q <= StIdle;
            end else begin
              tx_dat_q    <= rd_lo_q;
              resp_last_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Push must see the current full flag, so it is gated combinationally.
  assign o_tx_push  = (state_q == StResp) && !i_tx_full;
  assign o_tx_dat   = tx_dat_q;
  assign o_rx_pop   = rx_take_q;
  assign o_bus_cyc  = bus_cyc_q;
  assign o_bus_we   = bus_we_q;
  assign o_bus_addr = addr_q[AW-1:0];
  assign o_bus_dat  = wdat_q;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: FIFO/bus models plus a frame-level reference model.
module tb_uart_cmd_sequencer;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_empty = 1'b1;
  logic        rx_pop;
  logic [7:0]  tx_dat;
  logic        tx_push;
  logic        tx_full = 1'b0;
  logic        bus_cyc;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdat;
  logic [15:0] bus_rdat = 16'h0000;
  logic        bus_ack = 1'b0;
  logic        busy;

  uart_cmd_sequencer #(.AW(16), .DW(16), .TIMEOUT(Timeout)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_rx_dat   (rx_dat),
    .i_rx_empty (rx_empty),
    .o_rx_pop   (rx_pop),
    .o_tx_dat   (tx_dat),
    .o_tx_push  (tx_push),
    .i_tx_full  (tx_full),
    .o_bus_cyc  (bus_cyc),
    .o_bus_we   (bus_we),
    .o_bus_addr (bus_addr),
    .o_bus_dat  (bus_wdat),
    .i_bus_dat  (bus_rdat),
    .i_bus_ack  (bus_ack),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] dat;
  } op_t;

  logic [7:0]  src_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  op_t         exp_ops[$];
  op_t         got_ops[$];
  logic [15:0] slave_mem[logic [15:0]];
  logic [15:0] model_mem[logic [15:0]];

  int rx_gap       = 0;
  int ack_delay    = 0;
  bit no_ack       = 0;
  int full_mode    = 0;
  bit burst_armed  = 0;
  bit pop_seen     = 0;
  bit push_seen    = 0;

  function automatic logic [15:0] dflt_data(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  // RX FIFO: head byte registered, popped at the edge closing a pop cycle.
  int gap_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_seen = 0;
    if (rx_gap == 0) begin
      while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
    end else if (fifo_q.size() == 0 && src_q.size() > 0) begin
      if (gap_cnt >= rx_gap) begin
        fifo_q.push_back(src_q.pop_front());
        gap_cnt = 0;
      end else begin
        gap_cnt++;
      end
    end
    rx_empty = (fifo_q.size() == 0);
    rx_dat   = rx_empty ? 8'h00 : fifo_q[0];
  end

  // Bus slave: acks after ack_delay cycles; sprinkles stray acks while idle.
  int bus_wait = 0;
  always @(posedge clk) begin
    #1;
    if (!bus_cyc) begin
      bus_wait = 0;
      bus_ack  = ($urandom_range(0, 7) == 0);
      bus_rdat = 16'hDEAD;
    end else if (!no_ack && bus_wait >= ack_delay) begin
      bus_ack  = 1'b1;
      bus_rdat = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : dflt_data(bus_addr);
    end else begin
      bus_ack = 1'b0;
      bus_wait++;
    end
  end

  // TX full driver: none, random, or a single 4-cycle burst after the first pushed byte.
  int full_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (full_mode)
      1: tx_full = ($urandom_range(0, 2) == 0);
      2: begin
        if (burst_armed && push_seen) begin
          full_cnt    = 4;
          burst_armed = 0;
        end
        tx_full = (full_cnt > 0);
        if (full_cnt > 0) full_cnt--;
      end
      default: tx_full = 1'b0;
    endcase
    push_seen = 0;
  end

  int viol_pop_empty = 0, viol_pop_b2b = 0, viol_pop_busy = 0, viol_push_full = 0;
  int viol_txdat = 0, viol_bus_hold = 0, viol_cyc_drop = 0;
  int cyc_len = 0, last_cyc_len = 0;
  bit prev_pop = 0, prev_cyc = 0, prev_ack_cyc = 0, prev_wait_full = 0;
  logic [7:0]  prev_tx_dat;
  logic [32:0] bus_snap;
  op_t         mon_op;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pop = 0; prev_cyc = 0; prev_ack_cyc = 0; prev_wait_full = 0;
    end else begin
      if (rx_pop) begin
        pop_seen = 1;
        if (rx_empty) viol_pop_empty++;
        if (prev_pop) viol_pop_b2b++;
        if (bus_cyc || tx_push) viol_pop_busy++;
      end
      if (tx_push) begin
        if (tx_full) viol_push_full++;
        else begin
          got_tx.push_back(tx_dat);
          push_seen = 1;
        end
      end
      if (prev_wait_full && tx_full && tx_dat !== prev_tx_dat) viol_txdat++;
      prev_wait_full = tx_full && busy && !bus_cyc && !rx_pop;
      prev_tx_dat = tx_dat;
      prev_pop = rx_pop;
      if (prev_ack_cyc && bus_cyc) viol_cyc_drop++;
      if (bus_cyc) begin
        if (!prev_cyc) begin
          bus_snap = {bus_we, bus_addr, bus_wdat};
          cyc_len  = 0;
        end else if ({bus_we, bus_addr, bus_wdat} !== bus_snap) begin
          viol_bus_hold++;
        end
        cyc_len++;
        if (bus_ack) begin
          mon_op.we   = bus_we;
          mon_op.addr = bus_addr;
          mon_op.dat  = bus_we ? bus_wdat : 16'h0000;
          got_ops.push_back(mon_op);
          if (bus_we) slave_mem[bus_addr] = bus_wdat;
        end
      end else if (prev_cyc) begin
        last_cyc_len = cyc_len;
      end
      prev_ack_cyc = bus_cyc && bus_ack;
      prev_cyc = bus_cyc;
    end
  end

  task automatic send(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    slave_mem[a] = d;
    model_mem[a] = d;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    op_t o;
    send(8'h57); send(a[15:8]); send(a[7:0]); send(d[15:8]); send(d[7:0]);
    o.we = 1'b1; o.addr = a; o.dat = d;
    exp_ops.push_back(o);
    exp_tx.push_back(8'h06);
    model_mem[a] = d;
  endtask

  task automatic do_read(input logic [15:0] a);
    op_t o;
    logic [15:0] d;
    send(8'h52); send(a[15:8]); send(a[7:0]);
    d = model_mem.exists(a) ? model_mem[a] : dflt_data(a);
    o.we = 1'b0; o.addr = a; o.dat = 16'h0000;
    exp_ops.push_back(o);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  task automatic do_bad(input logic [7:0] c);
    send(c);
    exp_tx.push_back(8'h15);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int idle_run = 0;
    int n = 0;
    while (idle_run < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && src_q.size() == 0 && fifo_q.size() == 0 && !rx_pop) idle_run++;
      else idle_run = 0;
    end
    check_eq({tag, " drained"}, 64'(idle_run >= 3), 64'd1);
  endtask

  task automatic wait_cyc(input string tag, input int budget);
    int n = 0;
    while (!bus_cyc && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " bus_cyc reached"}, 64'(bus_cyc), 64'd1);
  endtask

  task automatic compare_all(input string tag);
    int n;
    check_eq({tag, " tx_count"}, 64'(got_tx.size()), 64'(exp_tx.size()));
    n = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
    for (int i = 0; i < n; i++) check_eq({tag, " tx_byte"}, 64'(got_tx[i]), 64'(exp_tx[i]));
    check_eq({tag, " op_count"}, 64'(got_ops.size()), 64'(exp_ops.size()));
    n = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) check_eq({tag, " bus_op"}, 64'(got_ops[i]), 64'(exp_ops[i]));
    got_tx.delete(); exp_tx.delete(); got_ops.delete(); exp_ops.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("reset bus_cyc drops", 64'(bus_cyc), 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    src_q.delete(); fifo_q.delete(); pop_seen = 0;
    no_ack = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset release pop/push", 64'({rx_pop, tx_push}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset outputs", 64'({busy, bus_cyc, bus_we, rx_pop, tx_push}), 64'd0);
    check_eq("reset tx_dat/addr/dat", 64'({tx_dat, bus_addr, bus_wdat}), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("release pop/push", 64'({rx_pop, tx_push}), 64'd0);

    ack_delay = 3;
    do_write(16'h0010, 16'hBEEF);
    wait_idle("write", 500);
    compare_all("write");
    check_eq("write busy after", 64'(busy), 64'd0);

    ack_delay = 1;
    preload(16'h1234, 16'hA55A);
    do_read(16'h1234);
    wait_idle("read", 500);
    compare_all("read");

    ack_delay = 0;
    do_bad(8'h41);
    do_read(16'h5678);
    wait_idle("bad+read", 500);
    compare_all("bad+read");

    rx_gap = 5; full_mode = 2; burst_armed = 1; ack_delay = 2;
    do_read(16'h0010);
    wait_idle("trickle", 1000);
    compare_all("trickle");
    rx_gap = 0; full_mode = 0;

    no_ack = 1;
    send(8'h57); send(8'h00); send(8'h20); send(8'h12); send(8'h34);
    wait_cyc("abort", 200);
    pulse_reset();
    do_read(16'h0020);
    wait_idle("after reset", 500);
    compare_all("after reset");

    no_ack = 1;
    last_cyc_len = 0;
`ifdef UARTMASTER_TIMEOUT_EN
    send(8'h52); send(8'h00); send(8'h30);
    exp_tx.push_back(8'h15);
    wait_idle("timeout", 500);
    check_eq("timeout cyc length", 64'(last_cyc_len), 64'(Timeout));
    compare_all("timeout");
    no_ack = 0;
`else
    send(8'h52); send(8'h00); send(8'h30);
    wait_cyc("hang", 200);
    repeat (120) @(negedge clk);
    check_eq("hang bus_cyc held", 64'({bus_cyc, busy}), 64'h3);
    pulse_reset();
    compare_all("hang");
`endif

    for (int f = 0; f < 40; f++) begin
      logic [15:0] a;
      int k;
      ack_delay = $urandom_range(0, 4);
      k = $urandom_range(0, 2);
      rx_gap = (k == 2) ? 3 : k;
      full_mode = 1;
      case ($urandom_range(0, 4))
        0: a = 16'h0010;
        1: a = 16'h0020;
        2: a = 16'hFFFF;
        3: a = 16'h1234;
        default: a = 16'($urandom);
      endcase
      k = $urandom_range(0, 9);
      if (k < 4) do_write(a, 16'($urandom));
      else if (k < 8) do_read(a);
      else begin
        logic [7:0] c;
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52) c = 8'hFF;
        do_bad(c);
      end
      wait_idle("random", 1000);
    end
    full_mode = 0;
    repeat (3) @(negedge clk);
    compare_all("random");

    check_eq("no pop while empty", 64'(viol_pop_empty), 64'd0);
    check_eq("no back-to-back pop", 64'(viol_pop_b2b), 64'd0);
    check_eq("no pop in bus/resp", 64'(viol_pop_busy), 64'd0);
    check_eq("no push while full", 64'(viol_push_full), 64'd0);
    check_eq("tx_dat held while full", 64'(viol_txdat), 64'd0);
    check_eq("bus fields held", 64'(viol_bus_hold), 64'd0);
    check_eq("cyc drops after ack", 64'(viol_cyc_drop), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command sequencer for the simulation UART master.
- Pops command bytes from the RX byte FIFO, decodes read/write frames and runs a single 16-bit bus cycle per frame.
- Pushes response bytes into the TX byte FIFO.
- Sits between the two UART FIFOs and the DCPU memory bus; it is the only block that drives the FIFOs' pop/push sides.

Parameters:
- AW, 16, bus address width (frame carries exactly 2 address bytes; AW <= 16).
- DW, 16, bus data width (frame carries exactly 2 data bytes).
- TIMEOUT, 255, bus ack timeout in clock cycles (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_rx_dat  in  8  RX FIFO head byte (registered FIFO output)
- i_rx_empty  in  1  RX FIFO empty
- o_rx_pop  out  1  RX FIFO pop strobe
- o_tx_dat  out  8  byte to TX FIFO
- o_tx_push  out  1  TX FIFO push strobe
- i_tx_full  in  1  TX FIFO full
- o_bus_cyc  out  1  bus cycle active
- o_bus_we  out  1  1 = write, 0 = read
- o_bus_addr  out  AW  bus address
- o_bus_dat  out  DW  write data
- i_bus_dat  in  DW  read data, valid with i_bus_ack
- i_bus_ack  in  1  bus acknowledge
- o_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state IDLE, byte counter 0, any partial frame discarded. Applies mid-frame, mid-bus-cycle and mid-response. No push or pop is issued in the cycle reset deasserts.
- Frame formats:
  - Write: 0x57 'W', ADDR_H, ADDR_L, DATA_H, DATA_L.
  - Read: 0x52 'R', ADDR_H, ADDR_L.
  - Any other command byte: consumed, then one NAK (0x15) is pushed. No bus cycle.
- Byte fetch is a two-state handshake:
  - RX_WAIT: if i_rx_empty == 0, go to RX_TAKE.
  - RX_TAKE: capture i_rx_dat and assert o_rx_pop for exactly that cycle, then return to RX_WAIT or the next state.
  - Consequences: minimum 2 cycles per byte; o_rx_pop is never asserted two consecutive cycles; o_rx_pop is never asserted while i_rx_empty == 1. This gives the registered FIFO output one cycle to settle after the FIFO becomes non-empty or after a pop.
- Main state flow:
  - IDLE -> CMD (fetch 1 byte) -> ADDR (fetch 2 bytes, high first).
  - Write: ADDR -> WDATA (fetch 2 bytes, high first) -> BUS.
  - Read: ADDR -> BUS.
  - Invalid command: CMD -> RESP with NAK.
- BUS state:
  - o_bus_cyc = 1; o_bus_we, o_bus_addr, o_bus_dat held stable until i_bus_ack is sampled high.
  - o_bus_cyc drops in the cycle after the ack.
  - A read captures i_bus_dat in the ack cycle. An ack arriving in the first cycle of o_bus_cyc is legal.
  - An ack while o_bus_cyc == 0 is ignored.
- RESP state:
  - Write response: one byte, ACK 0x06.
  - Read response: two bytes, DATA_H then DATA_L.
  - o_tx_push pulses one cycle per byte, only when i_tx_full == 0; otherwise the block waits with o_tx_dat held.
  - At most one push per cycle; back-to-back pushes are allowed.
  - After the last byte, return to IDLE.
- Frames are strictly serial: no RX pop occurs during BUS or RESP.
- Address bytes wider than AW are truncated to the low AW bits.

Optional Feature:
- Macro: UARTMASTER_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to BUS and increments each cycle without ack.
  - When the count reaches TIMEOUT with no ack, o_bus_cyc drops the next cycle and the response is a single NAK 0x15 (read data is not sent).
  - An ack in the same cycle the count hits TIMEOUT wins, and the normal response is sent.
- Without the macro: no counter; BUS waits indefinitely for ack.

Test Plan:
- Write frame 57 00 10 BE EF, ack after 3 cycles -> one bus write addr 0x0010 dat 0xBEEF, o_bus_we = 1; TX receives 0x06; o_busy low afterwards.
- Read frame 52 12 34, ack with i_bus_dat 0xA55A -> bus read addr 0x1234; TX receives A5 then 5A.
- Invalid command 0x41 followed by a valid read frame -> TX receives 0x15, then the read completes normally. Check that 0x41 is not treated as an address byte.
- RX bytes trickling in with i_rx_empty high for 5 cycles between bytes, plus i_tx_full high for 4 cycles during a read response -> correct frame; no pop while empty; push only when not full; o_tx_dat stable while waiting.
- Assert i_reset_n low during the BUS state of a write, then send a full read frame -> o_bus_cyc drops immediately, nothing is pushed for the aborted frame, and the read completes correctly.
- With UARTMASTER_TIMEOUT_EN and TIMEOUT = 8, a read with no ack -> o_bus_cyc high for 8 cycles, then TX receives 0x15. Without the macro, o_bus_cyc stays high for 100+ cycles.
